// File: rtl/alu_wb_retire_queue_pkg.sv
// rtl/alu_wb_retire_queue_pkg.sv - field widths and FIFO entry layout for the ALU writeback retire queue
package alu_wb_retire_queue_pkg;

    localparam int WFID_W  = 6;
    localparam int PC_W    = 32;
    localparam int VADDR_W = 10;
    localparam int SADDR_W = 9;

    typedef struct packed {
        logic [WFID_W-1:0]  wfid;
        logic [PC_W-1:0]    pc;
        logic [VADDR_W-1:0] vgpr_addr;
        logic [SADDR_W-1:0] sgpr_addr;
        logic               vgpr_wr_en;
        logic               sgpr_wr_en;
        logic               vcc_wr_en;
    } wb_entry_t;

    // VCC is written through the SGPR port, so it needs that grant too
    function automatic logic entry_needs_sgpr(input wb_entry_t e);
        return e.sgpr_wr_en | e.vcc_wr_en;
    endfunction

endpackage

// File: rtl/alu_wb_retire_queue_if.sv
// rtl/alu_wb_retire_queue_if.sv - ALU capture, write-port handshake and retire signals (ALU_WB_RETIRE_COUNT_EN adds retire count)
interface alu_wb_retire_queue_if;
    import alu_wb_retire_queue_pkg::*;

    logic [WFID_W-1:0]  in_wfid;
    logic [PC_W-1:0]    in_instr_pc;
    logic [VADDR_W-1:0] in_vgpr_dest_addr;
    logic [SADDR_W-1:0] in_sgpr_dest_addr;
    logic               in_instr_done;
    logic               in_vgpr_dest_wr_en;
    logic               in_sgpr_dest_wr_en;
    logic               in_vcc_wr_en;
    logic               in_vgpr_wr_gnt;
    logic               in_sgpr_wr_gnt;
    logic               out_vgpr_wr_req;
    logic               out_sgpr_wr_req;
    logic [VADDR_W-1:0] out_vgpr_dest_addr;
    logic [SADDR_W-1:0] out_sgpr_dest_addr;
    logic               out_vcc_wr_en;
    logic [WFID_W-1:0]  out_wb_wfid;
    logic               out_retire_valid;
    logic [WFID_W-1:0]  out_retire_wfid;
    logic [PC_W-1:0]    out_retire_pc;
    logic               out_alu_stall;
    logic               out_overflow;
`ifdef ALU_WB_RETIRE_COUNT_EN
    logic [31:0]        out_retire_count;
`endif

    modport master (
        output in_wfid, in_instr_pc, in_vgpr_dest_addr, in_sgpr_dest_addr, in_instr_done,
               in_vgpr_dest_wr_en, in_sgpr_dest_wr_en, in_vcc_wr_en, in_vgpr_wr_gnt, in_sgpr_wr_gnt,
        input  out_vgpr_wr_req, out_sgpr_wr_req, out_vgpr_dest_addr, out_sgpr_dest_addr, out_vcc_wr_en,
               out_wb_wfid, out_retire_valid, out_retire_wfid, out_retire_pc, out_alu_stall, out_overflow
`ifdef ALU_WB_RETIRE_COUNT_EN
        , input out_retire_count
`endif
    );

    modport slave (
        input  in_wfid, in_instr_pc, in_vgpr_dest_addr, in_sgpr_dest_addr, in_instr_done,
               in_vgpr_dest_wr_en, in_sgpr_dest_wr_en, in_vcc_wr_en, in_vgpr_wr_gnt, in_sgpr_wr_gnt,
        output out_vgpr_wr_req, out_sgpr_wr_req, out_vgpr_dest_addr, out_sgpr_dest_addr, out_vcc_wr_en,
               out_wb_wfid, out_retire_valid, out_retire_wfid, out_retire_pc, out_alu_stall, out_overflow
`ifdef ALU_WB_RETIRE_COUNT_EN
        , output out_retire_count
`endif
    );

endinterface

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - entry storage with wrapping pointers and occupancy count
module alu_wb_fifo
    import alu_wb_retire_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              din,
    input  logic                   pop,
    output wb_entry_t              dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t      mem_q [DEPTH];
    wb_entry_t      mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en;
    logic           rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_wb_retire_queue.sv
// rtl/alu_wb_retire_queue.sv - queues completed ALU instructions, arbitrates VGPR/SGPR write ports, retires in order (ALU_WB_RETIRE_COUNT_EN adds retire counter)
module alu_wb_retire_queue
    import alu_wb_retire_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    alu_wb_retire_queue_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic          head_valid;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          need_v, need_s;
    logic          v_req, s_req;
    logic          v_ok, s_ok;
    logic          retire;
    logic          got_v_q, got_v_d;
    logic          got_s_q, got_s_d;
    logic          overflow_q, overflow_d;

    always_comb begin
        push_entry.wfid       = bus.in_wfid;
        push_entry.pc         = bus.in_instr_pc;
        push_entry.vgpr_addr  = bus.in_vgpr_dest_addr;
        push_entry.sgpr_addr  = bus.in_sgpr_dest_addr;
        push_entry.vgpr_wr_en = bus.in_vgpr_dest_wr_en;
        push_entry.sgpr_wr_en = bus.in_sgpr_dest_wr_en;
        push_entry.vcc_wr_en  = bus.in_vcc_wr_en;
    end

    alu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_instr_done),
        .din   (push_entry),
        .pop   (retire),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign head_valid = ~fifo_empty;
    assign need_v     = head.vgpr_wr_en;
    assign need_s     = entry_needs_sgpr(head);
    assign v_req      = head_valid & need_v & ~got_v_q;
    assign s_req      = head_valid & need_s & ~got_s_q;

    // A grant only counts while its request is up, so it can complete the head this cycle
    assign v_ok   = ~need_v | got_v_q | (v_req & bus.in_vgpr_wr_gnt);
    assign s_ok   = ~need_s | got_s_q | (s_req & bus.in_sgpr_wr_gnt);
    assign retire = head_valid & v_ok & s_ok;

    always_comb begin
        got_v_d    = got_v_q;
        got_s_d    = got_s_q;
        overflow_d = overflow_q | (bus.in_instr_done & fifo_full & ~retire);
        if (retire) begin
            got_v_d = 1'b0;
            got_s_d = 1'b0;
        end else begin
            if (v_req & bus.in_vgpr_wr_gnt) got_v_d = 1'b1;
            if (s_req & bus.in_sgpr_wr_gnt) got_s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            got_v_q    <= 1'b0;
            got_s_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            got_v_q    <= got_v_d;
            got_s_q    <= got_s_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_vgpr_wr_req    = v_req;
    assign bus.out_sgpr_wr_req    = s_req;
    assign bus.out_vgpr_dest_addr = head_valid ? head.vgpr_addr : '0;
    assign bus.out_sgpr_dest_addr = head_valid ? head.sgpr_addr : '0;
    assign bus.out_vcc_wr_en      = head_valid & head.vcc_wr_en;
    assign bus.out_wb_wfid        = head_valid ? head.wfid : '0;
    assign bus.out_retire_valid   = retire;
    assign bus.out_retire_wfid    = retire ? head.wfid : '0;
    assign bus.out_retire_pc      = retire ? head.pc : '0;
    // One slot stays reserved for the entry already in the EX->WB register
    assign bus.out_alu_stall      = (fifo_count >= CW'(DEPTH - 1));
    assign bus.out_overflow       = overflow_q;

`ifdef ALU_WB_RETIRE_COUNT_EN
    logic [31:0] retire_count_q, retire_count_d;

    always_comb begin
        retire_count_d = retire_count_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_count_q <= '0;
        else     retire_count_q <= retire_count_d;
    end

    assign bus.out_retire_count = retire_count_q;
`else
`endif

endmodule

// File: doc/alu_wb_retire_queue.md
# alu_wb_retire_queue

Writeback/retire consumer at the far end of the ALU EX→WB pipeline register. Captures each completed ALU instruction (wfid, PC, destination addresses, write enables) into a small FIFO, requests the VGPR and SGPR write ports with a request/grant handshake, and emits one retire pulse per instruction toward issue/tracemon once every required write port has been granted. Back-pressures the ALU early enough to absorb the one-cycle pipeline-register latency.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_wfid  in  6  wavefront ID of completing instruction.
- in_instr_pc  in  32  instruction PC.
- in_vgpr_dest_addr  in  10  VGPR destination.
- in_sgpr_dest_addr  in  9  SGPR destination.
- in_instr_done  in  1  entry valid; capture qualifier.
- in_vgpr_dest_wr_en / in_sgpr_dest_wr_en / in_vcc_wr_en  in  1 each  write-enables.
- in_vgpr_wr_gnt / in_sgpr_wr_gnt  in  1 each  port grants.
- out_vgpr_wr_req / out_sgpr_wr_req  out  1 each  port requests.
- out_vgpr_dest_addr  out  10;  out_sgpr_dest_addr  out  9;  out_vcc_wr_en  out  1  (head-entry fields).
- out_wb_wfid  out  6  head wfid (valid with any req).
- out_retire_valid  out  1  retire pulse.
- out_retire_wfid  out  6;  out_retire_pc  out  32.
- out_alu_stall  out  1  back-pressure to ALU issue.
- out_overflow  out  1  sticky push-while-full error.

## Operation
- Push: at a clock edge with in_instr_done=1, write all in_* fields to tail; in_instr_done=0 is a bubble, ignored.
- Entry needs VGPR port if vgpr_wr_en; needs SGPR port if sgpr_wr_en or vcc_wr_en (VCC rides SGPR port).
- Head bookkeeping: got_v, got_s flags, cleared when head advances.
- out_vgpr_wr_req = head_valid & need_v & !got_v; same for SGPR. Requests independent; both may be high together.
- Grant counts only while matching req is high; grant without req ignored.
- Retire condition (combinational): head_valid & (!need_v | got_v | gnt_v) & (!need_s | got_s | gnt_s). out_retire_valid = retire condition; head pops at that edge; got flags clear.
- Entry with no write-enables retires the first cycle it is head.
- Push and pop in same cycle: both take effect, count unchanged; legal when full.
- Push while full without pop: entry dropped, out_overflow set until reset.
- out_alu_stall = (count ≥ DEPTH−1), from registered count.
- Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.

## Timing
- Reset values: all outputs 0, FIFO empty, flags clear, counter (if built) 0. Reset mid-operation discards all entries and partial grants; no retire for them.
- Push edge E0 → head visible and req high in cycle after E0 → with grant in that cycle, retire same cycle, pop at its edge. Minimum latency in_instr_done→out_retire_valid: 1 cycle.
- Throughput: 1 retire/cycle when grants immediate.
- Stall: asserted combinationally from count; ALU must hold off issue the cycle it is seen; the one in-flight pipeline-register entry fits in the reserved slot.

## Configuration
- ALU_WB_RETIRE_COUNT_EN defined: adds output out_retire_count (32 bits), incremented on every out_retire_valid, wraps at 2^32, reset to 0. Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package/definitions header: wfid, PC, VGPR/SGPR address widths, FIFO entry field layout.
- One sub-module: alu_wb_fifo (parameterised storage, pointers, count, full/empty); port-arbitration and retire logic stay in top.

## Test plan
- Single entry wfid=5, pc=0x100, vgpr_wr_en=1, gnt_v tied 1 → out_vgpr_wr_req 1 cycle, retire wfid=5 pc=0x100 next-cycle-after-push, count back to 0.
- Entry with vgpr_wr_en=1, vcc_wr_en=1; gnt_s at cycle 1, gnt_v at cycle 4 → sgpr req drops after cycle 1, retire exactly in cycle 4.
- Entry with no enables → retire without any req.
- Grants held 0, push 4 entries → out_alu_stall high at count 3; 5th push → dropped, out_overflow=1; release grants → 4 retires in push order.
- Full FIFO, push and retire same cycle → count stays 4, no overflow.
- Assert rst with 2 entries pending → all outputs 0 immediately, no retire after release; with ALU_WB_RETIRE_COUNT_EN, 3 retires → count=3, reset → 0.
